sync_tracker: RTL

//   Receive-side companion to the periodic sync generator. Watches an incoming sync strobe, locks to its period (rate+1 clocks).

---
 rtl/sync_tracker_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 33 +++
 rtl/sync_tracker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_tracker_pkg.sv
// -----------------------------------------------------------------------------
// sync_tracker_pkg
//   Shared definitions for the sync_tracker block.
//   - FSM state encoding (kept as plain 2-bit constants so older tools and
//     scripts that grep for numeric state values keep working).
//   - Width of the error statistics counter.
//   - Small helper used by the top to build saturating increments.
// -----------------------------------------------------------------------------
package sync_tracker_pkg;

    // Tracker states
    localparam logic [1:0] ST_SEARCH  = 2'd0;   // waiting for a first usable edge
    localparam logic [1:0] ST_ACQUIRE = 2'd1;   // counting consecutive good periods
    localparam logic [1:0] ST_LOCKED  = 2'd2;   // flywheeling on the locked period

    // Width of the accumulated early+late error counter
    localparam int ERRCNT_W = 16;

    // Saturating increment of the error counter: holds at all-ones.
    function automatic logic [ERRCNT_W-1:0] errcnt_inc(input logic [ERRCNT_W-1:0] value);
        if (value == {ERRCNT_W{1'b1}}) begin
            return value;
        end
        return value + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : sync_tracker_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Rising-edge detector for the incoming sync strobe.
//   The delayed copy sync_d is cleared synchronously whenever clear is high,
//   so a strobe that is already high when the tracker is released from
//   reset/disable counts as a fresh rising edge.
//
// Ports
//   clock    in   1   single clock, posedge
//   clear    in   1   synchronous clear of sync_d (reset | ~enable)
//   sync_in  in   1   raw incoming strobe
//   rise     out  1   high in the cycle sync_in rises (combinational)
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clock,
    input  logic clear,
    input  logic sync_in,
    output logic rise
);

    logic sync_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            sync_d <= 1'b0;
        end else begin
            sync_d <= sync_in;
        end
    end

    assign rise = sync_in & ~sync_d;

endmodule : sync_edge_det

// File: rtl/sync_tracker.sv
// -----------------------------------------------------------------------------
// sync_tracker
//   Receive-side companion of the periodic sync generator. Locks onto an
//   incoming sync strobe with period rate+1 clocks, then flywheels a phase
//   counter through missing or misplaced strobes. Produces a clean one-cycle
//   regenerated strobe, lock status, early/late error pulses and an optional
//   saturating error total.
//
// Parameters
//   WIDTH       width of rate and of the phase counter
//   LOCK_COUNT  consecutive good periods needed to declare lock (>=1)
//   MISS_LIMIT  consecutive errors while locked that drop lock (>=1)
//
// Ports
//   clock      in   1         single clock, all logic on posedge
//   reset      in   1         synchronous, active-high
//   enable     in   1         0 = hold in SEARCH with outputs cleared
//                             (err_count is kept)
//   rate       in   WIDTH     expected period minus 1
//   sync_in    in   1         incoming strobe, only rising edges are used
//   locked     out  1         high while in LOCKED
//   phase      out  WIDTH     internal phase counter
//   sync_out   out  1         regenerated strobe, aligned with phase==0
//   err_early  out  1         pulse: edge arrived before the expected slot
//   err_late   out  1         pulse: expected edge was missing
//   err_count  out  16        saturating total of error pulses
//
// Configuration
//   SYNC_TRACKER_STATS_EN  when defined, err_count is implemented; when
//                          undefined it is tied to zero and the counter
//                          logic is absent. Error pulses are unaffected.
// -----------------------------------------------------------------------------
module sync_tracker
    import sync_tracker_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [WIDTH-1:0]    rate,
    input  logic                sync_in,
    output logic                locked,
    output logic [WIDTH-1:0]    phase,
    output logic                sync_out,
    output logic                err_early,
    output logic                err_late,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [WIDTH-1:0]  CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [MISS_W-1:0] MISS_ONE  = {{(MISS_W-1){1'b0}}, 1'b1};
    // Value of good/miss *before* the edge that completes lock / drops lock
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic clear;
    logic rise;

    assign clear = reset | ~enable;

    sync_edge_det u_edge_det (
        .clock   (clock),
        .clear   (clear),
        .sync_in (sync_in),
        .rise    (rise)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state,  state_n;
    logic [WIDTH-1:0]  cnt,    cnt_n;
    logic [WIDTH-1:0]  rate_q, rate_q_n;
    logic [GOOD_W-1:0] good,   good_n;
    logic [MISS_W-1:0] miss,   miss_n;
    logic              early_n;
    logic              late_n;
    logic              sync_out_n;

    logic at_end;        // counter sits on the expected edge slot
    logic rate_changed;  // programmed rate no longer matches the captured one

    assign at_end       = (cnt == rate_q);
    assign rate_changed = (rate != rate_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rate_q_n = rate_q;
        good_n   = good;
        miss_n   = miss;
        early_n  = 1'b0;
        late_n   = 1'b0;

        // Regenerated strobe marks the last slot of a locked period; it is
        // registered so it lines up with phase wrapping to 0.
        sync_out_n = (state == ST_LOCKED) && at_end;

        case (state)
            ST_SEARCH: begin
                cnt_n  = '0;
                good_n = '0;
                miss_n = '0;
                if (rise) begin
                    rate_q_n = rate;
                    // A zero rate cannot describe a period; stay here.
                    if (rate != '0) begin
                        state_n = ST_ACQUIRE;
                    end
                end
            end

            ST_ACQUIRE: begin
                if (rate_changed) begin
                    state_n = ST_SEARCH;
                    cnt_n   = '0;
                    good_n  = '0;
                    miss_n  = '0;
                end else if (rise) begin
                    // Every edge re-phases the counter while acquiring.
                    cnt_n = '0;
                    if (at_end) begin
                        if (good == GOOD_LAST) begin
                            state_n = ST_LOCKED;
                            good_n  = '0;
                            miss_n  = '0;
                        end else begin
                            good_n = good + GOOD_ONE;
                        end
                    end else begin
                        good_n = '0;
                    end
                end else begin
                    // Expected slot passed without an edge: restart the run.
                    if (at_end) begin
                        good_n = '0;
                    end
                    if (cnt != CNT_MAX) begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end

            ST_LOCKED: begin
                if (rate_changed) begin
                    // Rate change has priority over any error this cycle.
                    state_n = ST_SEARCH;
                    cnt_n   = '0;
                    good_n  = '0;
                    miss_n  = '0;
                end else begin
                    // Flywheel: wrap on the period regardless of edges.
                    cnt_n = at_end ? '0 : cnt + CNT_ONE;
                    if (rise && at_end) begin
                        miss_n = '0;
                    end else if (rise || at_end) begin
                        early_n = rise;
                        late_n  = ~rise;
                        if (miss == MISS_LAST) begin
                            state_n = ST_SEARCH;
                            cnt_n   = '0;
                            good_n  = '0;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss + MISS_ONE;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_SEARCH;
                cnt_n   = '0;
                good_n  = '0;
                miss_n  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state     <= ST_SEARCH;
            cnt       <= '0;
            good      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            sync_out  <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            if (reset) begin
                rate_q <= '0;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rate_q    <= rate_q_n;
            good      <= good_n;
            miss      <= miss_n;
            locked    <= (state_n == ST_LOCKED);
            sync_out  <= sync_out_n;
            err_early <= early_n;
            err_late  <= late_n;
        end
    end

    assign phase = cnt;

    // ------------------------------------------------------------------
    // Error statistics
    // ------------------------------------------------------------------
`ifdef SYNC_TRACKER_STATS_EN
    logic [ERRCNT_W-1:0] err_total;

    // Updated on the same edge that launches the pulse, so the total already
    // includes an error in the cycle its pulse is visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_total <= '0;
        end else if (enable && (early_n || late_n)) begin
            err_total <= errcnt_inc(err_total);
        end
    end

    assign err_count = err_total;
`else
    assign err_count = '0;
`endif

endmodule : sync_tracker
